coin_acceptor: RTL and testbench
================================

// Module: coin_acceptor
// PURPOSE
//  Front end of the vending path: conditions three raw mechanical coin-sensor lines (1/2/5 CNY).
//  Outputs clean single-cycle, mutually exclusive, spaced coin pulses that drive the vending FSM's
//  i_one_cny/i_two_cny/i_five_cny directly.
//  Per channel: synchronise, debounce, edge-detect. Coins arriving together are queued and serialised.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive stable cycles needed before a debounced level changes (>=2)
//  GAP_CYCLES       2   idle cycles forced after every output pulse (>=1)
//  CNT_W            5   debounce counter width; must hold DEBOUNCE_CYCLES
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous reset, active-low
//  i_raw_one   in   1  raw 1 CNY sensor, async to clk, bouncy
//  i_raw_two   in   1  raw 2 CNY sensor, async to clk, bouncy
//  i_raw_five  in   1  raw 5 CNY sensor, async to clk, bouncy
//  i_inhibit   in   1  high: new coins rejected (e.g. while vend in progress)
//  o_one_cny   out  1  one-cycle pulse per accepted 1 CNY coin
//  o_two_cny   out  1  one-cycle pulse per accepted 2 CNY coin
//  o_five_cny  out  1  one-cycle pulse per accepted 5 CNY coin
//  o_reject    out  1  one-cycle pulse: coin edge seen while i_inhibit high
//  o_overrun   out  1  one-cycle pulse: coin edge on a channel whose pending flag is already set (coin lost)
//  o_busy      out  1  high when any pending flag is set or FSM not in S_IDLE
// BEHAVIOUR
//  Reset: async on rst low. All flops clear: sync, debounced level = 0, counters 0, pending 0, FSM S_IDLE.
//   All outputs 0. Reset mid-pulse/mid-gap aborts; pending coins are discarded.
//  Sync: 2-flop synchroniser per raw line.
//  Debounce, per channel:
//   - cnt increments each cycle sync_out != deb.
//   - cnt clears when sync_out == deb.
//   - when cnt reaches DEBOUNCE_CYCLES-1 while still differing, deb <= sync_out and cnt <= 0.
//   - Glitches shorter than DEBOUNCE_CYCLES cycles never change deb.
//  Edge: rise = deb & ~deb_q (registered copy); falling edges ignored.
//  Pending flag per channel, evaluated on rise:
//   - i_inhibit=1: no set; o_reject=1 next cycle.
//   - else pending=1: o_overrun=1 next cycle, flag stays 1.
//   - else flag set.
//   - Set and scheduler clear of the same flag in one cycle: set wins (flag stays 1).
//  Scheduler FSM (states in coin_pkg):
//   - S_IDLE: any pending -> S_PULSE. Selects highest-priority flag (one > two > five), clears it,
//     registers exactly that output high.
//   - S_PULSE (1 cycle, selected o_*_cny=1) -> S_GAP, gap_cnt <= GAP_CYCLES-1.
//   - S_GAP: all o_*_cny=0; gap_cnt decrements; at 0 -> S_IDLE.
//   - i_inhibit does not affect coins already pending; they are still delivered.
//  Guarantees:
//   - at most one o_*_cny high per cycle;
//   - >= GAP_CYCLES low cycles between pulses;
//   - pulse width exactly 1.
//  Latency, isolated coin, FSM idle: o_*_cny high in cycle DEBOUNCE_CYCLES+3 after the clock edge that
//   first samples raw high. Each coin already queued adds GAP_CYCLES+1.
//  Raw held high indefinitely = one coin; next coin requires release (debounced low) then rise.
// STRUCTURE
//  coin_pkg: FSM state encoding (S_IDLE/S_PULSE/S_GAP), channel index constants CH_ONE/CH_TWO/CH_FIVE,
//   default timing constants.
//  Sub-module coin_debounce (sync + debounce counter + rise detect), one instance per channel.
//  Top holds pending flags, priority select, scheduler FSM, registered outputs.
// TESTING (DEBOUNCE_CYCLES=16, GAP_CYCLES=2)
//  1. Reset value: rst low mid-gap with pending two -> all outputs 0 immediately.
//     After release no pulse appears, and o_busy=0.
//  2. Clean coin: raw_one high 40 cycles -> single o_one_cny pulse exactly 19 cycles after first
//     sampling edge; o_busy high until FSM back in S_IDLE.
//  3. Bounce: raw_two toggling every 3 cycles for 30 cycles, then stable high -> exactly one
//     o_two_cny; 10-cycle glitch alone -> no pulse.
//  4. Simultaneous coins: raw_one, raw_two, raw_five rise on the same edge -> pulses in order
//     one, two, five, separated by 2 low cycles (at cycles 19, 22, 25).
//  5. Inhibit: i_inhibit=1 during raw_five rise -> o_reject pulse, no o_five_cny.
//     A coin pending before inhibit is still delivered.
//  6. Overrun: second raw_one coin debounced while first still pending behind five -> o_overrun pulse,
//     only one o_one_cny delivered. Scoreboard: sum of pulses matches coins minus rejects/overruns.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared definitions for the coin acceptor: scheduler states, channel indices, default timing.
package coin_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PULSE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   localparam int N_CH    = 3;
   localparam int CH_ONE  = 0;
   localparam int CH_TWO  = 1;
   localparam int CH_FIVE = 2;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_GAP_CYCLES      = 2;
   localparam int DEF_CNT_W           = 5;

   // One-hot of the lowest set index; lower index = higher priority.
   function automatic logic [N_CH-1:0] pick_first(input logic [N_CH-1:0] req);
      logic [N_CH-1:0] sel;
      sel = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (req[i]) begin
            sel    = '0;
            sel[i] = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin sensor channel: two-flop synchroniser, stability counter, rising-edge detect.
module coin_debounce #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic rise
);

   logic             sync_a;
   logic             sync_b;
   logic             deb;
   logic             deb_q;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         deb    <= 1'b0;
         deb_q  <= 1'b0;
         cnt    <= '0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         deb_q  <= deb;
         if (sync_b == deb) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb <= sync_b;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign rise = deb & ~deb_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: per-channel debounce, pending flags, and a scheduler that serialises
// accepted coins into single-cycle, mutually exclusive, spaced pulses.
//
//   state   | meaning
//   S_IDLE  | waiting; grants the highest-priority pending coin
//   S_PULSE | selected o_*_cny is high for this one cycle
//   S_GAP   | forced low time after a pulse, counted by gap_cnt
module coin_acceptor
   import coin_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw_one,
   input  logic i_raw_two,
   input  logic i_raw_five,
   input  logic i_inhibit,
   output logic o_one_cny,
   output logic o_two_cny,
   output logic o_five_cny,
   output logic o_reject,
   output logic o_overrun,
   output logic o_busy
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   logic [N_CH-1:0]  raw_vec;
   logic [N_CH-1:0]  rise_vec;
   logic [N_CH-1:0]  pending;
   logic [N_CH-1:0]  grant;
   logic [GAP_W-1:0] gap_cnt;
   state_t           state;

   assign raw_vec = {i_raw_five, i_raw_two, i_raw_one};

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      coin_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_debounce (
         .clk  (clk),
         .rst  (rst),
         .raw  (raw_vec[ch]),
         .rise (rise_vec[ch])
      );
   end

   always_comb begin
      grant = '0;
      if (state == S_IDLE) grant = pick_first(pending);
   end

   // A new coin landing on a flag that is being granted this cycle re-arms it instead of
   // counting as an overrun, so neither coin is lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         gap_cnt    <= '0;
         pending    <= '0;
         o_one_cny  <= 1'b0;
         o_two_cny  <= 1'b0;
         o_five_cny <= 1'b0;
         o_reject   <= 1'b0;
         o_overrun  <= 1'b0;
      end else begin
         pending    <= (pending & ~grant) | (rise_vec & {N_CH{~i_inhibit}});
         o_reject   <= i_inhibit & (|rise_vec);
         o_overrun  <= ~i_inhibit & (|(rise_vec & pending & ~grant));
         o_one_cny  <= 1'b0;
         o_two_cny  <= 1'b0;
         o_five_cny <= 1'b0;
         case (state)
            S_IDLE: begin
               if (|pending) begin
                  state      <= S_PULSE;
                  o_one_cny  <= grant[CH_ONE];
                  o_two_cny  <= grant[CH_TWO];
                  o_five_cny <= grant[CH_FIVE];
               end
            end
            S_PULSE: begin
               state   <= S_GAP;
               gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            end
            S_GAP: begin
               // The idle cycle that follows counts as the last gap cycle.
               gap_cnt <= gap_cnt - 1'b1;
               if (gap_cnt <= GAP_W'(1)) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign o_busy = (|pending) | (state != S_IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: main instance at 16/2 timing, small instance at 2/12 for overrun.
module tb_coin_acceptor;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic raw_one = 1'b0, raw_two = 1'b0, raw_five = 1'b0, inhibit = 1'b0;
   logic o_one, o_two, o_five, o_rej, o_ovr, o_busy;
   logic raw2_one = 1'b0, raw2_two = 1'b0, raw2_five = 1'b0, inhibit2 = 1'b0;
   logic p_one, p_two, p_five, p_rej, p_ovr, p_busy;

   int cyc = 0;
   int total = 0;
   int passed = 0;
   int multi_hot = 0;
   int q_one[$], q_two[$], q_five[$], q_rej[$], q_ovr[$];
   int q2_one[$], q2_two[$], q2_five[$], q2_rej[$], q2_ovr[$];

   coin_acceptor #(.DEBOUNCE_CYCLES(16), .GAP_CYCLES(2), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .i_raw_one(raw_one), .i_raw_two(raw_two), .i_raw_five(raw_five),
      .i_inhibit(inhibit), .o_one_cny(o_one), .o_two_cny(o_two), .o_five_cny(o_five),
      .o_reject(o_rej), .o_overrun(o_ovr), .o_busy(o_busy)
   );

   coin_acceptor #(.DEBOUNCE_CYCLES(2), .GAP_CYCLES(12), .CNT_W(2)) dut_ovr (
      .clk(clk), .rst(rst), .i_raw_one(raw2_one), .i_raw_two(raw2_two), .i_raw_five(raw2_five),
      .i_inhibit(inhibit2), .o_one_cny(p_one), .o_two_cny(p_two), .o_five_cny(p_five),
      .o_reject(p_rej), .o_overrun(p_ovr), .o_busy(p_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (o_one)  q_one.push_back(cyc);
      if (o_two)  q_two.push_back(cyc);
      if (o_five) q_five.push_back(cyc);
      if (o_rej)  q_rej.push_back(cyc);
      if (o_ovr)  q_ovr.push_back(cyc);
      if (p_one)  q2_one.push_back(cyc);
      if (p_two)  q2_two.push_back(cyc);
      if (p_five) q2_five.push_back(cyc);
      if (p_rej)  q2_rej.push_back(cyc);
      if (p_ovr)  q2_ovr.push_back(cyc);
      if ($countones({o_one, o_two, o_five}) > 1) multi_hot++;
   end

   function automatic int first_of(input int q[$]);
      return (q.size() > 0) ? q[0] : -1;
   endfunction

   task automatic clear_q();
      q_one.delete(); q_two.delete(); q_five.delete(); q_rej.delete(); q_ovr.delete();
      q2_one.delete(); q2_two.delete(); q2_five.delete(); q2_rej.delete(); q2_ovr.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Advance until edge t0+r has happened; inputs driven now are first sampled at edge t0+r+1.
   task automatic to_rel(input int t0, input int r);
      while (cyc < t0 + r) tick(1);
   endtask

   task automatic test_reset();
      int t0;
      #3;
      total++;
      if ({o_one, o_two, o_five, o_rej, o_ovr, o_busy} !== 6'b0)
         $display("FAIL reset_initial: outputs=%b want 000000", {o_one, o_two, o_five, o_rej, o_ovr, o_busy});
      else passed++;
      tick(2);
      rst = 1'b1;
      tick(2);
      clear_q();
      t0 = cyc + 1;
      raw_one = 1'b1; raw_two = 1'b1;
      to_rel(t0, 20);
      total++;
      if (o_busy !== 1'b1 || q_one.size() != 1 || o_two !== 1'b0)
         $display("FAIL reset_midgap_setup: busy=%b one_pulses=%0d two=%b want busy=1 one_pulses=1 two=0",
                  o_busy, q_one.size(), o_two);
      else passed++;
      #2 rst = 1'b0;
      raw_one = 1'b0; raw_two = 1'b0;
      #1;
      total++;
      if ({o_one, o_two, o_five, o_rej, o_ovr, o_busy} !== 6'b0)
         $display("FAIL reset_async: outputs=%b want 000000", {o_one, o_two, o_five, o_rej, o_ovr, o_busy});
      else passed++;
      tick(3);
      rst = 1'b1;
      clear_q();
      tick(40);
      total++;
      if (q_one.size() + q_two.size() + q_five.size() + q_rej.size() + q_ovr.size() != 0 || o_busy !== 1'b0)
         $display("FAIL reset_discard: pulses=%0d busy=%b want pulses=0 busy=0",
                  q_one.size() + q_two.size() + q_five.size() + q_rej.size() + q_ovr.size(), o_busy);
      else passed++;
   endtask

   task automatic test_clean_coin();
      int t0;
      logic [3:0] busy_seen;
      clear_q();
      t0 = cyc + 1;
      raw_one = 1'b1;
      to_rel(t0, 17); busy_seen[3] = o_busy;
      to_rel(t0, 18); busy_seen[2] = o_busy;
      to_rel(t0, 20); busy_seen[1] = o_busy;
      to_rel(t0, 21); busy_seen[0] = o_busy;
      total++;
      if (busy_seen !== 4'b0110)
         $display("FAIL clean_busy: busy at r17/18/20/21=%b want 0110", busy_seen);
      else passed++;
      to_rel(t0, 40);
      raw_one = 1'b0;
      tick(25);
      total++;
      if (q_one.size() != 1 || first_of(q_one) != t0 + 19)
         $display("FAIL clean_one_time: n=%0d first=%0d want n=1 first=%0d", q_one.size(), first_of(q_one) - t0, 19);
      else passed++;
      total++;
      if (q_two.size() + q_five.size() + q_rej.size() + q_ovr.size() != 0)
         $display("FAIL clean_others: stray pulses=%0d want 0", q_two.size() + q_five.size() + q_rej.size() + q_ovr.size());
      else passed++;
   endtask

   task automatic test_bounce();
      int t0;
      clear_q();
      t0 = cyc + 1;
      raw_two = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         to_rel(t0, 3 * i - 1);
         raw_two = (i % 2 == 0);
      end
      to_rel(t0, 70);
      raw_two = 1'b0;
      tick(25);
      total++;
      if (q_two.size() != 1 || first_of(q_two) != t0 + 49)
         $display("FAIL bounce_two: n=%0d rel=%0d want n=1 rel=49", q_two.size(), first_of(q_two) - t0);
      else passed++;
      total++;
      if (q_one.size() + q_five.size() != 0)
         $display("FAIL bounce_others: stray=%0d want 0", q_one.size() + q_five.size());
      else passed++;

      clear_q();
      raw_two = 1'b1; tick(10); raw_two = 1'b0; tick(40);
      total++;
      if (q_two.size() != 0 || o_busy !== 1'b0)
         $display("FAIL glitch10: n=%0d busy=%b want n=0 busy=0", q_two.size(), o_busy);
      else passed++;

      raw_two = 1'b1; tick(15); raw_two = 1'b0; tick(40);
      total++;
      if (q_two.size() != 0)
         $display("FAIL glitch15: n=%0d want 0", q_two.size());
      else passed++;

      clear_q();
      t0 = cyc + 1;
      raw_five = 1'b1; tick(16); raw_five = 1'b0; tick(40);
      total++;
      if (q_five.size() != 1 || first_of(q_five) != t0 + 19)
         $display("FAIL stable16_five: n=%0d rel=%0d want n=1 rel=19", q_five.size(), first_of(q_five) - t0);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int t0;
      clear_q();
      multi_hot = 0;
      t0 = cyc + 1;
      raw_one = 1'b1; raw_two = 1'b1; raw_five = 1'b1;
      to_rel(t0, 40);
      raw_one = 1'b0; raw_two = 1'b0; raw_five = 1'b0;
      tick(25);
      total++;
      if (q_one.size() != 1 || first_of(q_one) != t0 + 19)
         $display("FAIL b2b_one: n=%0d rel=%0d want n=1 rel=19", q_one.size(), first_of(q_one) - t0);
      else passed++;
      total++;
      if (q_two.size() != 1 || first_of(q_two) != t0 + 22)
         $display("FAIL b2b_two: n=%0d rel=%0d want n=1 rel=22", q_two.size(), first_of(q_two) - t0);
      else passed++;
      total++;
      if (q_five.size() != 1 || first_of(q_five) != t0 + 25)
         $display("FAIL b2b_five: n=%0d rel=%0d want n=1 rel=25", q_five.size(), first_of(q_five) - t0);
      else passed++;
      total++;
      if (multi_hot != 0)
         $display("FAIL b2b_exclusive: multi-hot cycles=%0d want 0", multi_hot);
      else passed++;
   endtask

   task automatic test_inhibit();
      int t0;
      clear_q();
      t0 = cyc + 1;
      raw_one = 1'b1; raw_two = 1'b1;
      to_rel(t0, 2);
      raw_five = 1'b1;
      to_rel(t0, 19);
      inhibit = 1'b1;
      to_rel(t0, 40);
      inhibit = 1'b0;
      raw_one = 1'b0; raw_two = 1'b0; raw_five = 1'b0;
      tick(25);
      total++;
      if (q_rej.size() != 1 || first_of(q_rej) != t0 + 21)
         $display("FAIL inhibit_reject: n=%0d rel=%0d want n=1 rel=21", q_rej.size(), first_of(q_rej) - t0);
      else passed++;
      total++;
      if (q_five.size() != 0)
         $display("FAIL inhibit_no_five: n=%0d want 0", q_five.size());
      else passed++;
      total++;
      if (q_two.size() != 1 || first_of(q_two) != t0 + 22 || q_one.size() != 1 || first_of(q_one) != t0 + 19)
         $display("FAIL inhibit_pending_delivered: one rel=%0d two rel=%0d want 19 22",
                  first_of(q_one) - t0, first_of(q_two) - t0);
      else passed++;
      total++;
      if (q_one.size() + q_two.size() + q_five.size() != 3 - q_rej.size() - q_ovr.size())
         $display("FAIL inhibit_scoreboard: pulses=%0d want %0d",
                  q_one.size() + q_two.size() + q_five.size(), 3 - q_rej.size() - q_ovr.size());
      else passed++;
   endtask

   // Long gap lets a second 1 CNY coin debounce while the first is still queued behind the five.
   task automatic test_overrun();
      int t0;
      clear_q();
      t0 = cyc + 1;
      raw2_five = 1'b1;
      to_rel(t0, 1);  raw2_one = 1'b1;
      to_rel(t0, 5);  raw2_one = 1'b0;
      to_rel(t0, 9);  raw2_one = 1'b1;
      to_rel(t0, 40);
      raw2_one = 1'b0; raw2_five = 1'b0;
      tick(20);
      total++;
      if (q2_ovr.size() != 1 || first_of(q2_ovr) != t0 + 14)
         $display("FAIL overrun_pulse: n=%0d rel=%0d want n=1 rel=14", q2_ovr.size(), first_of(q2_ovr) - t0);
      else passed++;
      total++;
      if (q2_five.size() != 1 || first_of(q2_five) != t0 + 5)
         $display("FAIL overrun_five: n=%0d rel=%0d want n=1 rel=5", q2_five.size(), first_of(q2_five) - t0);
      else passed++;
      total++;
      if (q2_one.size() != 1 || first_of(q2_one) != t0 + 18)
         $display("FAIL overrun_one: n=%0d rel=%0d want n=1 rel=18", q2_one.size(), first_of(q2_one) - t0);
      else passed++;
      total++;
      if (q2_one.size() + q2_two.size() + q2_five.size() != 3 - q2_rej.size() - q2_ovr.size() || q2_rej.size() != 0)
         $display("FAIL overrun_scoreboard: pulses=%0d rejects=%0d want pulses=%0d rejects=0",
                  q2_one.size() + q2_two.size() + q2_five.size(), q2_rej.size(), 3 - q2_ovr.size());
      else passed++;
      total++;
      if (p_busy !== 1'b0)
         $display("FAIL overrun_idle: busy=%b want 0", p_busy);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_clean_coin();
      test_bounce();
      test_back_to_back();
      test_inhibit();
      test_overrun();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
